pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32I pipeline.
- Inputs: ID/EX operand info, EX branch outcome, MEM-stage data-memory handshake.
- Outputs: per-register enable and flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Contains a memory-wait FSM with timeout detection and saturating performance counters for stall and flush events.

---
 rtl/pipeline_hazard_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for a 5-stage RV32I pipeline.
//
// It decides, each cycle, which pipeline registers load, which load a bubble,
// and whether the PC advances. The inputs it uses are:
//   - ID/EX operand info, to detect load-use hazards
//   - the EX redirect (taken branch or jump)
//   - the MEM-stage data-memory handshake
//
// A small FSM (RUN / MEM_WAIT / ERROR) tracks how long MEM has been waiting on
// data memory. If the wait goes past TIMEOUT cycles, the FSM freezes the
// pipeline and raises a sticky error until the next reset.
//
// Parameters
//   TIMEOUT  max consecutive cycles MEM may wait on dmem_ready (>= 1)
//   CNT_W    width of the saturating performance counters
//
// Ports
//   clk, reset                   clock, synchronous active-high reset
//   id_rs1/id_rs2, id_use_rs1/2  source operands of the instruction in ID
//   ex_mem_read, ex_rd           load-in-EX flag and its destination
//   ex_redirect                  EX resolved a taken branch/jump
//   mem_req, dmem_ready          MEM-stage data-memory handshake
//   pc_en, *_en, *_flush         per-register load enables / bubble strobes
//   mem_timeout                  sticky memory-wait timeout error
//   stall_cycles                 cycles with pc_en = 0 (saturating)
//   flush_events                 cycles where a redirect was acted on (saturating)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_flush,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state_q,        state_d;
    logic [WAIT_W-1:0] wait_cnt_q,     wait_cnt_d;
    logic              mem_timeout_q,  mem_timeout_d;
    logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0]  flush_events_q, flush_events_d;

    logic load_use;
    logic mem_stall;
    logic redirect_fire;

    // Register x0 never creates a hazard.
    assign load_use  = ex_mem_read && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
    assign mem_stall = mem_req && !dmem_ready;

    // -----------------------------------------------------------------------
    // Control decode (priority order) and next-state logic.
    // -----------------------------------------------------------------------
    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_en       = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_en      = 1'b1;
        mem_wb_en      = 1'b1;
        mem_wb_flush   = 1'b0;
        redirect_fire  = 1'b0;
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_timeout_d  = mem_timeout_q;
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;

        if (reset) begin
            // Let every pipeline register see its own reset: all enables
            // stay high and no flushes are issued.
        end else if (state_q == ST_ERROR) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (mem_stall) begin
            // Hold everything up to MEM. A bubble goes into WB so the stalled
            // instruction does not write back twice. EX is held, so any
            // redirect there is seen again once memory completes.
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (ex_redirect) begin
            // Instructions in IF and ID are on the wrong path. That is why a
            // coincident load-use hazard does not matter here.
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            redirect_fire = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (mem_stall) begin
                    if (wait_cnt_q == TIMEOUT_V) begin
                        state_d       = ST_ERROR;
                        mem_timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        if (!pc_en && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
        if (redirect_fire && (flush_events_q != CNT_MAX)) begin
            flush_events_d = flush_events_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            wait_cnt_q     <= '0;
            mem_timeout_q  <= 1'b0;
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_timeout_q  <= mem_timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign mem_timeout  = mem_timeout_q;
    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Runs directed scenarios first, then randomized traffic. Each cycle's
// outputs are compared against a behavioural model. The model works from
// the consecutive memory-stall count and the priority rules, and it does
// not keep an FSM of its own.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

    localparam int TO     = 4;
    localparam int CW     = 6;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect;
    logic          mem_req, dmem_ready;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic          ex_mem_en, mem_wb_en, mem_wb_flush, mem_timeout;
    logic [CW-1:0] stall_cycles, flush_events;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_use_rs1   (id_use_rs1),
        .id_use_rs2   (id_use_rs2),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .ex_redirect  (ex_redirect),
        .mem_req      (mem_req),
        .dmem_ready   (dmem_ready),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .id_ex_en     (id_ex_en),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .mem_wb_flush (mem_wb_flush),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model state
    int m_run   = 0;   // consecutive memory-stall cycles seen so far
    bit m_err   = 0;
    int m_stall = 0;
    int m_flush = 0;
    bit known   = 0;   // model state is defined once a reset has been applied

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        reset       = 1'b0;
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        ex_mem_read = 1'b0;
        ex_rd       = 5'd0;
        ex_redirect = 1'b0;
        mem_req     = 1'b0;
        dmem_ready  = 1'b0;
    endtask

    // Entered at posedge+1 with the inputs already applied. Outputs are
    // checked mid-cycle, then the model advances on the clock edge.
    // Control vector order:
    // {pc,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_en,mem_wb_flush}
    task automatic cycle(input string tag);
        bit         ms, lu, fire;
        logic [7:0] e, got;
        ms   = mem_req && !dmem_ready;
        lu   = ex_mem_read && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        fire = 0;
        if (reset)            e = 8'b1101_0110;
        else if (m_err)       e = 8'b0000_0000;
        else if (ms)          e = 8'b0000_0011;
        else if (ex_redirect) begin e = 8'b1111_1110; fire = 1; end
        else if (lu)          e = 8'b0001_1110;
        else                  e = 8'b1101_0110;
        #4;
        got = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en, mem_wb_flush};
        $display("cyc=%0d %s rst=%b ms=%b lu=%b redir=%b ctrl=%b stall=%0d flush=%0d to=%b",
                 cyc, tag, reset, ms, lu, ex_redirect, got, stall_cycles, flush_events, mem_timeout);
        check_val({tag, "/ctrl"}, {24'd0, got}, {24'd0, e});
        if (known) begin
            check_val({tag, "/timeout"}, {31'd0, mem_timeout}, {31'd0, m_err});
            check_val({tag, "/stall_cnt"}, {{(32-CW){1'b0}}, stall_cycles}, m_stall);
            check_val({tag, "/flush_cnt"}, {{(32-CW){1'b0}}, flush_events}, m_flush);
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_run = 0; m_err = 0; m_stall = 0; m_flush = 0; known = 1;
        end else begin
            if (!e[7] && m_stall < CNTMAX) m_stall++;
            if (fire && m_flush < CNTMAX) m_flush++;
            if (!m_err) begin
                if (ms) begin
                    m_run++;
                    // Error once the stall run outlasts TIMEOUT waiting cycles
                    if (m_run > TO) m_err = 1;
                end else begin
                    m_run = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;

        cycle("reset");
        clear_inputs();
        cycle("idle");

        // Load-use hazard on rs1
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        cycle("load_use");
        clear_inputs();
        cycle("after_lu");

        // x0 and unused-operand cases are not hazards
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        cycle("x0");
        clear_inputs();
        ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 0; id_rs1 = 3; id_use_rs1 = 1;
        cycle("unused_rs2");
        clear_inputs();

        // Branch beats load-use
        ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; ex_redirect = 1;
        cycle("br_vs_lu");
        clear_inputs();
        cycle("after_br");

        // Three-cycle memory wait
        mem_req = 1;
        repeat (3) cycle("mem_wait");
        dmem_ready = 1;
        cycle("mem_done");
        clear_inputs();
        cycle("after_mem");

        // Redirect held across a two-cycle stall
        mem_req = 1; ex_redirect = 1;
        repeat (2) cycle("redir_wait");
        dmem_ready = 1;
        cycle("redir_rel");
        clear_inputs();
        cycle("after_redir");

        // Zero-wait access
        mem_req = 1; dmem_ready = 1;
        cycle("zero_wait");
        clear_inputs();

        // Timeout, freeze, then reset
        mem_req = 1;
        repeat (6) cycle("timeout");
        clear_inputs();
        cycle("frozen");
        check_val("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
        reset = 1;
        cycle("reset2");
        clear_inputs();
        cycle("post_reset");
        check_val("post_reset_to", {31'd0, mem_timeout}, 32'd0);

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 300; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_rd       = 5'($urandom_range(0, 3));
            ex_redirect = ($urandom_range(0, 3) == 0);
            mem_req     = ($urandom_range(0, 2) != 0);
            dmem_ready  = ($urandom_range(0, 2) == 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
